xlr8_tone_gen: RTL and testbench

AVR-mapped square-wave tone generator that drives the two speaker pins upstream of the speaker output stage. Firmware programs a 16-bit half-period and an 8-bit cycle count through data-memory registers, then strobes START. The block plays the tone for the programmed number of full periods, or continuously, and then returns to silence. It raises a one-cycle done pulse at the end of a finite tone.

---
 rtl/xlr8_tone_gen_pkg.sv | 26 ++
 rtl/xlr8_tone_gen_if.sv | 16 +
 rtl/xlr8_tone_gen_core.sv | 104 ++++++++++
 rtl/xlr8_tone_gen.sv | 92 +++++++++
 tb/tb_xlr8_tone_gen.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/xlr8_tone_gen_pkg.sv
// Shared types and constants for the xlr8 tone generator.
// CTRL bit positions, register widths and the half-period clamp helper.
package xlr8_tone_pkg;
    localparam int DATA_W = 8;
    localparam int PER_W  = 16;
    localparam int DUR_W  = 8;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_START = 1;
    localparam int CTRL_CONT  = 2;
    localparam int CTRL_INV2  = 3;
    localparam int CTRL_BUSY  = 7;

    localparam logic [PER_W-1:0] PER_ONE = {{(PER_W-1){1'b0}}, 1'b1};
    localparam logic [DUR_W-1:0] DUR_ONE = {{(DUR_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } tone_state_t;

    // A zero half-period would never toggle, so it plays as the shortest one.
    function automatic logic [PER_W-1:0] per_clamp(input logic [PER_W-1:0] per);
        return (per == '0) ? PER_ONE : per;
    endfunction
endpackage

// File: rtl/xlr8_tone_gen_if.sv
// AVR data-memory bus as seen by the tone generator.
// The master drives address/strobes/write data; the slave returns read data.
interface xlr8_tone_gen_if;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       io_out_en;
    logic [7:0] ramadr;
    logic       ramre;
    logic       ramwe;
    logic       dm_sel;

    modport master (output dbus_in, ramadr, ramre, ramwe, dm_sel,
                    input  dbus_out, io_out_en);
    modport slave  (input  dbus_in, ramadr, ramre, ramwe, dm_sel,
                    output dbus_out, io_out_en);
endinterface

// File: rtl/xlr8_tone_gen_core.sv
// Tone sequencer: FSM, tick prescaler, half-period counter and period counter.
//
// state   | meaning
// IDLE    | silent, waiting for START with EN set
// PLAY    | toggling wave every active_per ticks
module xlr8_tone_core
    import xlr8_tone_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clken,
    input  logic             i_start,
    input  logic             i_en,
    input  logic             i_cont,
    input  logic [PER_W-1:0] i_per,
    input  logic [DUR_W-1:0] i_dur,
    output logic             o_wave,
    output logic             o_busy,
    output logic             o_done
);
    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    tone_state_t      r_state;
    tone_state_t      w_state_nxt;
    logic [15:0]      r_pre;
    logic [PER_W-1:0] r_hcnt;
    logic [PER_W-1:0] r_active_per;
    logic [DUR_W-1:0] r_cyc_left;
    logic             r_wave;
    logic             r_done;
    logic             w_start_ok;
    logic             w_tick;
    logic             w_hp_end;
    logic             w_rise;
    logic             w_last;

    assign w_start_ok = i_start && i_en && ((i_dur != '0) || i_cont);
    assign w_tick     = (r_state == ST_PLAY) && (r_pre == PRE_LAST);
    assign w_hp_end   = w_tick && (r_hcnt == r_active_per - PER_ONE);
    assign w_rise     = w_hp_end && !r_wave;
    assign w_last     = w_rise && !i_cont && (r_cyc_left <= DUR_ONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else if (clken) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!i_en) begin
            w_state_nxt = ST_IDLE;
        end else if (w_start_ok) begin
            w_state_nxt = ST_PLAY;
        end else if ((r_state == ST_PLAY) && w_last) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        o_busy = (r_state == ST_PLAY);
        o_wave = r_wave;
        o_done = r_done;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pre        <= '0;
            r_hcnt       <= '0;
            r_active_per <= '0;
            r_cyc_left   <= '0;
            r_wave       <= 1'b0;
            r_done       <= 1'b0;
        end else if (clken) begin
            r_done <= i_en && !w_start_ok && w_last;
            if (!i_en) begin
                r_wave <= 1'b0;
            end else if (w_start_ok) begin
                r_pre        <= '0;
                r_hcnt       <= '0;
                r_active_per <= per_clamp(i_per);
                r_cyc_left   <= i_dur;
                r_wave       <= 1'b1;
            end else if (r_state == ST_PLAY) begin
                r_pre <= w_tick ? '0 : r_pre + 16'd1;
                if (w_hp_end) begin
                    // PER is only sampled here so a phase is never cut short.
                    r_hcnt       <= '0;
                    r_active_per <= per_clamp(i_per);
                    r_wave       <= w_last ? 1'b0 : !r_wave;
                    if (w_rise && !i_cont && (r_cyc_left != '0)) begin
                        r_cyc_left <= r_cyc_left - DUR_ONE;
                    end
                end else if (w_tick) begin
                    r_hcnt <= r_hcnt + PER_ONE;
                end
            end
        end
    end
endmodule

// File: rtl/xlr8_tone_gen.sv
// AVR-mapped square-wave tone generator driving the two speaker pins.
// Holds the register file and read mux; sequencing lives in xlr8_tone_core.
module xlr8_tone_gen
    import xlr8_tone_pkg::*;
#(
    parameter logic [7:0] TONE_CTRL_ADDR = 8'h00,
    parameter logic [7:0] TONE_PERL_ADDR = 8'h00,
    parameter logic [7:0] TONE_PERH_ADDR = 8'h00,
    parameter logic [7:0] TONE_DUR_ADDR  = 8'h00,
    parameter int         PRESCALE       = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clken,
    xlr8_tone_gen_if.slave  avr,
    output logic            spk1_out,
    output logic            spk2_out,
    output logic            done_pulse
);
    logic             w_sel_ctrl, w_sel_perl, w_sel_perh, w_sel_dur;
    logic             w_wr_ctrl, w_wr_perl, w_wr_perh, w_wr_dur;
    logic             r_en, r_cont, r_inv2;
    logic [PER_W-1:0] r_per;
    logic [DUR_W-1:0] r_dur;
    logic             w_en, w_cont, w_start;
    logic             w_wave, w_busy;
    logic [DATA_W-1:0] w_ctrl_rd;

    assign w_sel_ctrl = avr.dm_sel && (avr.ramadr == TONE_CTRL_ADDR);
    assign w_sel_perl = avr.dm_sel && (avr.ramadr == TONE_PERL_ADDR);
    assign w_sel_perh = avr.dm_sel && (avr.ramadr == TONE_PERH_ADDR);
    assign w_sel_dur  = avr.dm_sel && (avr.ramadr == TONE_DUR_ADDR);
    assign w_wr_ctrl  = clken && avr.ramwe && w_sel_ctrl;
    assign w_wr_perl  = clken && avr.ramwe && w_sel_perl;
    assign w_wr_perh  = clken && avr.ramwe && w_sel_perh;
    assign w_wr_dur   = clken && avr.ramwe && w_sel_dur;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_en   <= 1'b0;
            r_cont <= 1'b0;
            r_inv2 <= 1'b0;
            r_per  <= '0;
            r_dur  <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en   <= avr.dbus_in[CTRL_EN];
                r_cont <= avr.dbus_in[CTRL_CONT];
                r_inv2 <= avr.dbus_in[CTRL_INV2];
            end
            if (w_wr_perl) r_per[7:0]  <= avr.dbus_in;
            if (w_wr_perh) r_per[15:8] <= avr.dbus_in;
            if (w_wr_dur)  r_dur       <= avr.dbus_in;
        end
    end

    // The core sees a CTRL write in the same cycle, so EN/START in one write start a tone.
    assign w_en    = w_wr_ctrl ? avr.dbus_in[CTRL_EN]   : r_en;
    assign w_cont  = w_wr_ctrl ? avr.dbus_in[CTRL_CONT] : r_cont;
    assign w_start = w_wr_ctrl && avr.dbus_in[CTRL_START];

    xlr8_tone_core #(.PRESCALE(PRESCALE)) u_core (
        .clk     (clk),
        .rstn    (rstn),
        .clken   (clken),
        .i_start (w_start),
        .i_en    (w_en),
        .i_cont  (w_cont),
        .i_per   (r_per),
        .i_dur   (r_dur),
        .o_wave  (w_wave),
        .o_busy  (w_busy),
        .o_done  (done_pulse)
    );

    always_comb begin
        w_ctrl_rd            = '0;
        w_ctrl_rd[CTRL_EN]   = r_en;
        w_ctrl_rd[CTRL_CONT] = r_cont;
        w_ctrl_rd[CTRL_INV2] = r_inv2;
        w_ctrl_rd[CTRL_BUSY] = w_busy;
    end

    assign avr.dbus_out  = ({DATA_W{w_sel_ctrl}} & w_ctrl_rd)
                         | ({DATA_W{w_sel_perl}} & r_per[7:0])
                         | ({DATA_W{w_sel_perh}} & r_per[15:8])
                         | ({DATA_W{w_sel_dur}}  & r_dur);
    assign avr.io_out_en = (w_sel_ctrl || w_sel_perl || w_sel_perh || w_sel_dur) && avr.ramre;

    assign spk1_out = w_busy & w_wave;
    assign spk2_out = w_busy & (w_wave ^ r_inv2);
endmodule

// File: tb/tb_xlr8_tone_gen.sv
// Bench for xlr8_tone_gen: tones are predicted as a list of phase lengths and
// compared cycle by cycle against the speaker pins and done pulse.
module tb_xlr8_tone_gen;
    localparam int         PS     = 4;
    localparam logic [7:0] A_CTRL = 8'h40;
    localparam logic [7:0] A_PERL = 8'h41;
    localparam logic [7:0] A_PERH = 8'h42;
    localparam logic [7:0] A_DUR  = 8'h43;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic clken = 1'b0;
    logic spk1, spk2, done;

    xlr8_tone_gen_if avr_if ();

    xlr8_tone_gen #(
        .TONE_CTRL_ADDR (A_CTRL),
        .TONE_PERL_ADDR (A_PERL),
        .TONE_PERH_ADDR (A_PERH),
        .TONE_DUR_ADDR  (A_DUR),
        .PRESCALE       (PS)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .clken      (clken),
        .avr        (avr_if),
        .spk1_out   (spk1),
        .spk2_out   (spk2),
        .done_pulse (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // expected tone: alternating high/low phase lengths in clken cycles
    int   ph[$];
    logic inv2_m;
    int   stop_k;
    int   mid_k;
    logic [7:0] mid_addr, mid_data;
    logic mid_restart;
    logic rand_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        avr_if.dm_sel  = 1'b1;
        avr_if.ramwe   = 1'b1;
        avr_if.ramadr  = addr;
        avr_if.dbus_in = data;
        clken = 1'b1;
        step();
        avr_if.dm_sel = 1'b0;
        avr_if.ramwe  = 1'b0;
    endtask

    task automatic rd(input logic [7:0] addr, output logic [7:0] d);
        avr_if.dm_sel = 1'b1;
        avr_if.ramre  = 1'b1;
        avr_if.ramadr = addr;
        #1;
        d = avr_if.dbus_out;
        check_val("io_out_en", avr_if.io_out_en, 1);
        avr_if.dm_sel = 1'b0;
        avr_if.ramre  = 1'b0;
        #1;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        rd(addr, d);
        check_val(tag, d, exp);
    endtask

    task automatic program_tone(input logic [15:0] per, input logic [7:0] dur);
        wr(A_PERL, per[7:0]);
        wr(A_PERH, per[15:8]);
        wr(A_DUR, dur);
    endtask

    task automatic set_phases(input int per, input int dur);
        int p;
        p = ((per == 0) ? 1 : per) * PS;
        ph.delete();
        for (int i = 0; i < 2 * dur; i++) ph.push_back(p);
    endtask

    function automatic int total_len();
        int s;
        s = 0;
        foreach (ph[i]) s += ph[i];
        return s;
    endfunction

    function automatic logic exp_wave(input int k);
        int acc;
        acc = 0;
        foreach (ph[i]) begin
            if (k <= acc + ph[i]) return (i % 2) == 0;
            acc += ph[i];
        end
        return 1'b0;
    endfunction

    // k is the number of clken cycles since the START write (k=1 first busy cycle)
    task automatic run_tone();
        int   k, cyc, tot;
        logic pl, w, used;
        k = 1; cyc = 0; used = 1'b0;
        tot = total_len();
        while (k <= stop_k && cyc < 20000) begin
            pl = (k <= tot);
            w  = exp_wave(k);
            check_val("spk1", spk1, pl & w);
            check_val("spk2", spk2, pl & (w ^ inv2_m));
            check_val("done", done, (k == tot + 1));
            if (k == mid_k && !used) begin
                wr(mid_addr, mid_data);
                used = 1'b1;
                k = mid_restart ? 1 : k + 1;
            end else begin
                clken = rand_clk ? ($urandom_range(0, 3) != 0) : 1'b1;
                step();
                if (clken) k++;
            end
            cyc++;
        end
        clken = 1'b1;
        check_val("run_bound", (cyc < 20000), 1);
    endtask

    task automatic finite_tone(input int per, input int dur, input logic inv2);
        program_tone(16'(per), 8'(dur));
        set_phases(per, dur);
        inv2_m = inv2;
        stop_k = total_len() + 3;
        wr(A_CTRL, {4'b0, inv2, 3'b011});
        run_tone();
        rd_check("ctrl_after_tone", A_CTRL, {4'b0, inv2, 3'b001});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v0, v1, v2;
        avr_if.dbus_in = '0; avr_if.ramadr = '0;
        avr_if.ramre = 1'b0; avr_if.ramwe = 1'b0; avr_if.dm_sel = 1'b0;
        inv2_m = 1'b0; mid_k = -1; mid_addr = '0; mid_data = '0;
        mid_restart = 1'b0; rand_clk = 1'b0; stop_k = 0;

        repeat (3) step();
        rstn = 1'b1;
        clken = 1'b1;
        step();
        check_val("rst_spk1", spk1, 0);
        check_val("rst_spk2", spk2, 0);
        check_val("rst_done", done, 0);
        check_val("rst_ioen", avr_if.io_out_en, 0);
        check_val("rst_dbus_nosel", avr_if.dbus_out, 0);
        rd_check("rst_ctrl", A_CTRL, 8'h00);
        rd_check("rst_perl", A_PERL, 8'h00);
        rd_check("rst_perh", A_PERH, 8'h00);
        rd_check("rst_dur", A_DUR, 8'h00);

        // register read-back
        v0 = 8'($urandom); v1 = 8'($urandom); v2 = 8'($urandom);
        wr(A_PERL, v0); wr(A_PERH, v1); wr(A_DUR, v2);
        rd_check("rb_perl", A_PERL, v0);
        rd_check("rb_perh", A_PERH, v1);
        rd_check("rb_dur", A_DUR, v2);
        wr(A_CTRL, 8'hFE);
        rd_check("rb_ctrl_mask", A_CTRL, 8'h0C);
        check_val("rb_no_start", spk1, 0);
        wr(A_CTRL, 8'h00);
        rd_check("rb_ctrl_clr", A_CTRL, 8'h00);

        finite_tone(3, 2, 1'b0);

        // continuous tone with inverted speaker 2, then EN cleared
        program_tone(16'd3, 8'd1);
        set_phases(3, 40);
        inv2_m = 1'b1;
        stop_k = 150;
        wr(A_CTRL, 8'h0F);
        run_tone();
        rd_check("cont_busy", A_CTRL, 8'h8D);
        wr(A_CTRL, 8'h0C);
        for (int i = 0; i < 20; i++) begin
            check_val("en0_spk1", spk1, 0);
            check_val("en0_spk2", spk2, 0);
            check_val("en0_done", done, 0);
            step();
        end
        rd_check("en0_ctrl", A_CTRL, 8'h0C);

        // PER changed 3 -> 5 during the first high phase
        program_tone(16'd3, 8'd3);
        ph.delete();
        ph.push_back(3 * PS);
        for (int i = 0; i < 5; i++) ph.push_back(5 * PS);
        inv2_m = 1'b0;
        stop_k = total_len() + 3;
        mid_k = 5; mid_addr = A_PERL; mid_data = 8'd5; mid_restart = 1'b0;
        wr(A_CTRL, 8'h03);
        run_tone();
        mid_k = -1;

        // DUR=0 without CONT never starts
        program_tone(16'd3, 8'd0);
        wr(A_CTRL, 8'h03);
        for (int i = 0; i < 20; i++) begin
            check_val("dur0_spk1", spk1, 0);
            check_val("dur0_done", done, 0);
            step();
        end
        rd_check("dur0_ctrl", A_CTRL, 8'h01);

        // START while busy restarts with the full DUR
        program_tone(16'd2, 8'd2);
        set_phases(2, 2);
        inv2_m = 1'b0;
        stop_k = total_len() + 3;
        mid_k = 20; mid_addr = A_CTRL; mid_data = 8'h03; mid_restart = 1'b1;
        wr(A_CTRL, 8'h03);
        run_tone();
        mid_k = -1;

        finite_tone(0, 2, 1'b0);

        // randomized tones with gappy clken
        rand_clk = 1'b1;
        for (int t = 0; t < 6; t++) begin
            finite_tone($urandom_range(0, 4), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
        end
        rand_clk = 1'b0;

        // async reset mid-tone
        program_tone(16'd3, 8'd2);
        wr(A_CTRL, 8'h03);
        repeat (3) step();
        check_val("pre_rst_spk1", spk1, 1);
        check_val("pre_rst_spk2", spk2, 1);
        #2;
        rstn = 1'b0;
        #1;
        check_val("async_rst_spk1", spk1, 0);
        check_val("async_rst_spk2", spk2, 0);
        check_val("async_rst_done", done, 0);
        step();
        rstn = 1'b1;
        step();
        rd_check("post_rst_ctrl", A_CTRL, 8'h00);
        rd_check("post_rst_perl", A_PERL, 8'h00);
        rd_check("post_rst_dur", A_DUR, 8'h00);
        finite_tone(1, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
